// File: rtl/wb_ram_arbiter.sv
// wb_ram_arbiter: two-master round-robin Wishbone arbiter with burst cap in front of the on-chip RAM.
// Optional stall timeout per grant is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_ram_arbiter #(
  parameter int MAX_BURST      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_m0_cyc,
  input  logic        i_m0_stb,
  input  logic        i_m0_we,
  input  logic [3:0]  i_m0_sel,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_data,
  output logic [31:0] o_m0_data,
  output logic        o_m0_ack,
  output logic        o_m0_err,
  input  logic        i_m1_cyc,
  input  logic        i_m1_stb,
  input  logic        i_m1_we,
  input  logic [3:0]  i_m1_sel,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_data,
  output logic [31:0] o_m1_data,
  output logic        o_m1_ack,
  output logic        o_m1_err,
  output logic        o_s_cyc,
  output logic        o_s_stb,
  output logic        o_s_we,
  output logic [3:0]  o_s_sel,
  output logic [31:0] o_s_addr,
  output logic [31:0] o_s_data,
  input  logic [31:0] i_s_data,
  input  logic        i_s_ack,
  output logic [1:0]  o_grant
);
  localparam int BW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] SAT = BW'(MAX_BURST);
  localparam logic [BW-1:0] LAST = BW'((MAX_BURST < 1) ? 0 : MAX_BURST - 1);
  typedef enum logic [1:0] {IDLE, G0, G1} state_t;
  state_t state;
  logic rr_last;
  logic [BW-1:0] burst_cnt;
  logic g0, g1, cur_cyc, cur_stb, oth_req, cap, tmo, grant_end;
  assign g0 = state == G0;
  assign g1 = state == G1;
  assign cur_cyc = g1 ? i_m1_cyc : i_m0_cyc;
  assign cur_stb = g1 ? i_m1_stb : i_m0_stb;
  assign oth_req = g1 ? i_m0_cyc : i_m1_cyc;
  // >= lets a saturated counter hand over at the first ack after a competitor shows up
  assign cap = (MAX_BURST != 0) && i_s_ack && (burst_cnt >= LAST) && oth_req;
`ifdef WB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] to_cnt;
  assign tmo = (g0 || g1) && cur_stb && !i_s_ack && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign o_m0_err = g0 && tmo;
  assign o_m1_err = g1 && tmo;
  always_ff @(posedge i_clk) begin
    if (i_rst || state == IDLE || grant_end || i_s_ack) to_cnt <= '0;
    else if (cur_stb) to_cnt <= to_cnt + 1'b1;
  end
`else
  assign tmo = 1'b0;
  assign o_m0_err = 1'b0;
  assign o_m1_err = 1'b0;
`endif
  assign grant_end = !cur_cyc || cap || tmo;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      rr_last   <= 1'b1;
      burst_cnt <= '0;
    end else if (state == IDLE) begin
      burst_cnt <= '0;
      if (i_m0_cyc || i_m1_cyc) state <= (i_m0_cyc && (!i_m1_cyc || rr_last)) ? G0 : G1;
    end else if (grant_end) begin
      state     <= oth_req ? (g0 ? G1 : G0) : IDLE;
      rr_last   <= g1;
      burst_cnt <= '0;
    end else if (i_s_ack && burst_cnt != SAT) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end
  assign o_s_cyc   = g0 ? i_m0_cyc  : g1 ? i_m1_cyc  : 1'b0;
  assign o_s_stb   = g0 ? i_m0_stb  : g1 ? i_m1_stb  : 1'b0;
  assign o_s_we    = g0 ? i_m0_we   : g1 ? i_m1_we   : 1'b0;
  assign o_s_sel   = g0 ? i_m0_sel  : g1 ? i_m1_sel  : 4'b0;
  assign o_s_addr  = g0 ? i_m0_addr : g1 ? i_m1_addr : 32'b0;
  assign o_s_data  = g0 ? i_m0_data : g1 ? i_m1_data : 32'b0;
  assign o_m0_ack  = g0 && i_s_ack;
  assign o_m1_ack  = g1 && i_s_ack;
  assign o_m0_data = g0 ? i_s_data : 32'b0;
  assign o_m1_data = g1 ? i_s_data : 32'b0;
  assign o_grant   = {g1, g0};
endmodule

// File: doc/wb_ram_arbiter.md
Name: wb_ram_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter that shares the on-chip RAM between the instruction-fetch port (m0) and the load/store port (m1) of the 5-stage core.
- Sits between the core's bus interfaces and the RAM slave.
- Grant is registered and round-robin, with an optional per-grant burst cap so neither master starves.
- The RAM slave acks combinationally in the same cycle as cyc&stb; the arbiter adds no wait states inside a grant.

Parameters:
- MAX_BURST, 4: acked transfers allowed per grant before forced hand-over when the other master is requesting. 0 = unlimited.
- TIMEOUT_CYCLES, 16: stall limit used only with WB_ARB_TIMEOUT_EN. Must be ≥ 2.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_mN_cyc, i_mN_stb, i_mN_we  in  1 each  master N (N = 0, 1) bus cycle, strobe, write-enable.
- i_mN_sel  in  4  master N byte select.
- i_mN_addr  in  32  master N byte address.
- i_mN_data  in  32  master N write data.
- o_mN_data  out  32  read data returned to master N.
- o_mN_ack  out  1  transfer acknowledge to master N.
- o_mN_err  out  1  timeout error to master N (WB_ARB_TIMEOUT_EN only; otherwise tied 0).
- o_s_cyc, o_s_stb, o_s_we  out  1 each  to RAM slave.
- o_s_sel  out  4  to RAM slave.
- o_s_addr, o_s_data  out  32 each  to RAM slave.
- i_s_data  in  32  RAM read data.
- i_s_ack  in  1  RAM acknowledge.
- o_grant  out  2  one-hot grant status: 01 = m0, 10 = m1, 00 = idle.

Behaviour:
- Registered state
  - state: IDLE / G0 / G1.
  - rr_last: last master served, 1 bit.
  - burst_cnt: width clog2(MAX_BURST+1), minimum 1.
  - to_cnt: with macro only.
- Reset (i_rst=1 at clock edge)
  - state=IDLE, rr_last=1 (so m0 wins the first tie), burst_cnt=0, to_cnt=0.
  - Takes priority over any other event, including a transfer in progress. An aborted master sees no ack and must hold or retry.
- Outputs (combinational from state, no other logic)
  - IDLE: all o_s_* = 0; o_m*_ack = 0; o_m*_data = 0; o_grant = 00.
  - Gx: o_s_* = master x fields verbatim.
  - Gx: o_mx_ack = i_s_ack; o_mx_data = i_s_data.
  - Gx: the non-granted master gets ack = 0 and data = 0.
- IDLE transitions
  - Requests: req0 = i_m0_cyc, req1 = i_m1_cyc.
  - Single request: go to that Gx.
  - Both: go to G(~rr_last).
  - None: stay in IDLE.
  - Grant latency: first possible ack is 1 cycle after cyc rises from IDLE.
- Gx: end of grant
  - Condition: release (i_mx_cyc = 0), or cap reached (MAX_BURST ≠ 0, i_s_ack = 1, burst_cnt == MAX_BURST-1, other master requesting).
  - Next state: G(other) if the other master is requesting, else IDLE. Switching goes directly Gx→Gy with no idle bubble.
  - On exit: rr_last = x, burst_cnt = 0.
- Gx: grant continues
  - burst_cnt increments on i_s_ack, saturating at MAX_BURST.
- Cap with no competitor
  - A master that reaches the cap while the other is idle keeps the grant.
  - burst_cnt stays saturated until a competitor appears; hand-over then happens at the next ack.
- Preempted master keeps cyc/stb asserted (Wishbone rule) and is re-granted later.
- Simultaneous events: i_s_ack and the end condition in the same cycle means the ack is delivered to x that cycle; the switch happens at the edge.
- Address, data and sel are not modified. Byte-lane and size handling remain the slave's job.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - to_cnt counts cycles in Gx with i_mx_stb = 1 and i_s_ack = 0; it clears on ack or state change.
  - When to_cnt == TIMEOUT_CYCLES-1 with no ack: o_mx_err = 1 for that one cycle, and the grant ends as if released (rr_last = x, next state by the normal rule).
- Not defined: no counter is built and o_m0_err = o_m1_err = 0 constantly.

Test Plan:
1. Hold i_rst=1 for 2 cycles with both cyc=1 → o_grant=00 and o_s_cyc=0 throughout. Release reset → next cycle o_grant=01.
2. m1 alone: read addr 0x0000_0010, sel 1111, slave returns 0xDEADBEEF with ack → cyc rises at cycle N. Cycle N+1: o_grant=10, o_s_addr=0x10, o_m1_ack=1, o_m1_data=0xDEADBEEF, o_m0_ack=0.
3. MAX_BURST=4, both masters requesting continuously, slave acks every cycle → acks go 4 to m0, then 4 to m1, and so on, with no cycle having o_grant=00.
4. m0 granted, drops cyc after 2 acks while m1 requests → next cycle o_grant=10 and burst_cnt=0.
5. Assert i_rst for 1 cycle while in G1 after 2 acks → next cycle o_grant=00 and burst_cnt=0. With both requesting, m0 is granted first.
6. WB_ARB_TIMEOUT_EN set, TIMEOUT_CYCLES=16, m0 strobes, i_s_ack held 0 → o_m0_err pulses on the 16th stalled cycle and the grant passes to m1 if requesting. Without the macro, o_m0_err stays 0 for 100 cycles.
